// File: rtl/ahb_slv_if.sv
// ---------------------------------------------------------------------------
// ahb_slv_if
//
// AHB slave-side front end. Each accepted AHB beat (address phase followed by
// data phase) becomes one request/acknowledge transaction on a simple local
// bus that feeds a register file or SRAM. Wait states are taken directly from
// the local acknowledge. Illegal accesses and local errors produce the
// two-cycle AHB ERROR response.
//
// Parameters
//   ADDR_WIDTH  local byte-address width. A transfer with any of
//               HADDR[31:ADDR_WIDTH] set is illegal.
//
// Ports
//   CLK, RST_N          clock (rising edge); synchronous active-low reset
//   HSEL .. HREADY      AHB slave inputs (address phase and write data)
//   HREADYOUT, HRESP,   AHB slave response
//   HRDATA
//   LocReq .. LocWData  local request; held until LocAck
//   LocAck, LocErr,     local completion, error (qualified by LocAck) and
//   LocRData            read data (valid with LocAck)
// ---------------------------------------------------------------------------
module ahb_slv_if #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  LocReq,
    output logic                  LocWrite,
    output logic [ADDR_WIDTH-1:0] LocAddr,
    output logic [2:0]            LocSize,
    output logic [3:0]            LocByteEn,
    output logic [31:0]           LocWData,
    input  logic                  LocAck,
    input  logic                  LocErr,
    input  logic [31:0]           LocRData
);

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic [3:0]            be_q;

    logic                  accept;
    logic                  illegal;
    logic                  load;
    logic [3:0]            be_new;
    logic                  unused_ok;

    // Bursts are handled beat by beat and BUSY is treated like IDLE, so the
    // burst type and HTRANS[0] carry no information for this block.
    assign unused_ok = ^{HTRANS[0], HBURST};

    // A beat is taken only when the previous data phase on the bus has
    // completed (HREADY) and the transfer is NONSEQ or SEQ.
    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        illegal = 1'b0;
        if (HSIZE > 3'd2)                           illegal = 1'b1;
        if (HSIZE == 3'd1 && HADDR[0])              illegal = 1'b1;
        if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)   illegal = 1'b1;
        if (HADDR[31:ADDR_WIDTH] != '0)             illegal = 1'b1;
    end

    // Little-endian lane enables. Only evaluated for legal sizes, so the
    // default arm is the word case.
    always_comb begin
        case (HSIZE)
            3'd0:    be_new = 4'b0001 << HADDR[1:0];
            3'd1:    be_new = 4'b0011 << {HADDR[1], 1'b0};
            default: be_new = 4'b1111;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of block order.
    always_ff @(posedge CLK) begin
        // NOTE: the captured address-phase registers are few and drive
        // outputs, so they are reset along with the state rather than left
        // uninitialised.
        if (!RST_N) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            be_q    <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                addr_q  <= HADDR[ADDR_WIDTH-1:0];
                write_q <= HWRITE;
                size_q  <= HSIZE;
                be_q    <= be_new;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case statement can infer a latch.
        state_next = state;
        load       = 1'b0;
        HREADYOUT  = 1'b1;
        HRESP      = RESP_OKAY;
        HRDATA     = '0;
        LocReq     = 1'b0;
        LocWrite   = 1'b0;
        LocAddr    = '0;
        LocSize    = '0;
        LocByteEn  = '0;
        LocWData   = '0;

        case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    HRESP = RESP_ERROR;
                end
                if (accept) begin
                    state_next = illegal ? ST_ERR1 : ST_DATA;
                    load       = ~illegal;
                end else begin
                    state_next = ST_IDLE;
                end
            end

            ST_DATA: begin
                LocReq    = 1'b1;
                LocWrite  = write_q;
                LocAddr   = addr_q;
                LocSize   = size_q;
                LocByteEn = be_q;
                LocWData  = HWDATA;
                HREADYOUT = LocAck & ~LocErr;
                HRDATA    = write_q ? '0 : LocRData;
                if (LocAck) begin
                    if (LocErr) begin
                        // The failing cycle itself is the first ERROR wait
                        // state's predecessor: ERR1 still drives HREADYOUT low.
                        state_next = ST_ERR1;
                    end else if (accept) begin
                        state_next = illegal ? ST_ERR1 : ST_DATA;
                        load       = ~illegal;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = RESP_ERROR;
                state_next = ST_ERR2;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_slv_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_slv_if
//
// Self-checking bench for ahb_slv_if. A pipelined AHB master issues directed
// and random beats; for each beat the expected outcome (legal or not, local
// request fields, wait-state count, response, read data) is queued. A local
// responder plays back the planned acknowledge delay / error / read data, and
// an independent monitor pops the queue as beats are accepted and checks the
// DUT outputs every cycle until the data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_slv_if;

    localparam int ADDR_WIDTH = 12;
    localparam int WAIT_LIMIT = 64;

    logic                  CLK    = 1'b0;
    logic                  RST_N  = 1'b0;
    logic                  HSEL   = 1'b0;
    logic [31:0]           HADDR  = '0;
    logic [1:0]            HTRANS = '0;
    logic                  HWRITE = 1'b0;
    logic [2:0]            HSIZE  = '0;
    logic [2:0]            HBURST = '0;
    logic [31:0]           HWDATA = '0;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [31:0]           HRDATA;
    logic                  LocReq;
    logic                  LocWrite;
    logic [ADDR_WIDTH-1:0] LocAddr;
    logic [2:0]            LocSize;
    logic [3:0]            LocByteEn;
    logic [31:0]           LocWData;
    logic                  LocAck   = 1'b0;
    logic                  LocErr   = 1'b0;
    logic [31:0]           LocRData = '0;

    // Single-slave system: the bus-wide ready is this slave's ready.
    assign HREADY = HREADYOUT;

    ahb_slv_if #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .LocReq    (LocReq),
        .LocWrite  (LocWrite),
        .LocAddr   (LocAddr),
        .LocSize   (LocSize),
        .LocByteEn (LocByteEn),
        .LocWData  (LocWData),
        .LocAck    (LocAck),
        .LocErr    (LocErr),
        .LocRData  (LocRData)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        legal;
        int          delay;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        int          delay;
        logic        err;
        logic [31:0] rdata;
    } plan_t;

    txn_t  exp_q[$];
    plan_t plan_q[$];
    int    checks     = 0;
    int    errors     = 0;
    bit    mon_en     = 1'b0;
    bit    mon_active = 1'b0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference rules ----------------
    function automatic logic is_legal(input logic [31:0] addr, input logic [2:0] size);
        int unsigned bytes;
        if (size > 3'd2) return 1'b0;
        bytes = 32'd1 << size;
        return ((addr % bytes) == 0) && (addr < (32'd1 << ADDR_WIDTH));
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [2:0] size);
        int unsigned bytes;
        int unsigned mask;
        bytes = 32'd1 << size;
        mask  = (32'd1 << bytes) - 32'd1;
        return 4'(mask << (addr % 4));
    endfunction

    function automatic txn_t mk(input logic [31:0] addr, input logic write,
                                input logic [2:0] size, input int delay, input logic err);
        txn_t t;
        t.addr  = addr;
        t.write = write;
        t.size  = size;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.delay = delay;
        t.err   = err;
        t.legal = is_legal(addr, size);
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [31:0] addr;
        logic [2:0]  size;
        int          sel;
        sel  = int'($urandom_range(0, 15));
        size = (sel == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        addr = 32'($urandom_range(0, 4095));
        if (sel == 1) addr = $urandom;
        else if (sel < 12) addr = addr & ~((32'd1 << size) - 32'd1);
        return mk(addr, 1'($urandom_range(0, 1)), size, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0));
    endfunction

    // ---------------- AHB master ----------------
    // Called just after a rising edge: presents one address phase, holds it
    // until HREADY, then drives the write data for the beat just taken.
    task automatic phase(input logic sel, input logic [1:0] trans, input txn_t t);
        int    n;
        plan_t p;
        HSEL   = sel;
        HTRANS = trans;
        HADDR  = t.addr;
        HWRITE = t.write;
        HSIZE  = t.size;
        HBURST = 3'($urandom_range(0, 7));
        if (sel && trans[1]) begin
            exp_q.push_back(t);
            if (t.legal) begin
                p.delay = t.delay;
                p.err   = t.err;
                p.rdata = t.rdata;
                plan_q.push_back(p);
            end
        end
        n = 0;
        @(negedge CLK);
        while (!HREADYOUT && n < WAIT_LIMIT) begin
            @(negedge CLK);
            n++;
        end
        if (!HREADYOUT) fail("hready_timeout");
        @(posedge CLK);
        #1;
        HWDATA = (sel && trans[1] && t.write) ? t.wdata : $urandom;
    endtask

    task automatic send(input txn_t t, input logic seq);
        phase(1'b1, seq ? 2'b11 : 2'b10, t);
    endtask

    task automatic idle_phase();
        txn_t t;
        t = mk($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 0, 1'b0);
        case ($urandom_range(0, 2))
            0:       phase(1'b1, 2'b00, t);
            1:       phase(1'b1, 2'b01, t);
            default: phase(1'b0, 2'($urandom_range(2, 3)), t);
        endcase
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mon_active || exp_q.size() != 0) && n < WAIT_LIMIT) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        check("monitor_idle", 64'(mon_active), 64'(0));
    endtask

    // ---------------- local responder ----------------
    initial begin : responder
        plan_t p;
        int    cnt;
        bit    busy;
        busy = 1'b0;
        cnt  = 0;
        p.delay = 0;
        p.err   = 1'b0;
        p.rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (LocReq) begin
                if (!busy) begin
                    if (plan_q.size() == 0) begin
                        fail("unexpected_locreq");
                        p.delay = 0;
                        p.err   = 1'b0;
                        p.rdata = '0;
                    end else begin
                        p = plan_q.pop_front();
                    end
                    cnt  = p.delay;
                    busy = 1'b1;
                end
                if (cnt == 0) begin
                    LocAck   = 1'b1;
                    LocErr   = p.err;
                    LocRData = p.rdata;
                    busy     = 1'b0;
                end else begin
                    LocAck   = 1'b0;
                    LocErr   = 1'($urandom_range(0, 1));
                    LocRData = $urandom;
                    cnt--;
                end
            end else begin
                // Noise outside a request must be ignored by the DUT.
                busy     = 1'b0;
                LocAck   = 1'($urandom_range(0, 1));
                LocErr   = 1'($urandom_range(0, 1));
                LocRData = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        txn_t       cur;
        int         waits;
        int         lreq_cycles;
        int         exp_waits;
        logic       err_exp;
        logic [1:0] prev_hresp;
        waits       = 0;
        lreq_cycles = 0;
        prev_hresp  = '0;
        cur         = mk('0, 1'b0, '0, 0, 1'b0);
        forever begin
            @(negedge CLK);
            if (!mon_en) begin
                mon_active = 1'b0;
                continue;
            end
            if (mon_active) begin
                if (LocReq) begin
                    lreq_cycles++;
                    if (cur.legal) begin
                        check("loc_fields",
                              64'({LocAddr, LocWrite, LocSize, LocByteEn}),
                              64'({cur.addr[ADDR_WIDTH-1:0], cur.write, cur.size,
                                   exp_be(cur.addr, cur.size)}));
                        if (cur.write) check("loc_wdata", 64'(LocWData), 64'(cur.wdata));
                    end
                end else begin
                    check("loc_quiet", 64'({LocWrite, LocAddr, LocSize, LocByteEn, LocWData}), 64'(0));
                end
                if (HREADYOUT) begin
                    err_exp   = !cur.legal || cur.err;
                    exp_waits = !cur.legal ? 1 : (cur.err ? cur.delay + 2 : cur.delay);
                    check("hresp", 64'(HRESP), err_exp ? 64'(1) : 64'(0));
                    check("wait_states", 64'(waits), 64'(exp_waits));
                    check("locreq_cycles", 64'(lreq_cycles), cur.legal ? 64'(cur.delay + 1) : 64'(0));
                    if (err_exp) check("err_first_cycle", 64'(prev_hresp), 64'(1));
                    else check("hrdata", 64'(HRDATA), cur.write ? 64'(0) : 64'(cur.rdata));
                    mon_active = 1'b0;
                end else begin
                    waits++;
                end
            end else begin
                check("idle_outputs",
                      64'({HREADYOUT, HRESP, LocReq, LocWrite, LocAddr, LocSize, LocByteEn}),
                      64'({1'b1, 2'b00, 1'b0, 1'b0, {ADDR_WIDTH{1'b0}}, 3'b000, 4'b0000}));
                check("idle_data", 64'({HRDATA, LocWData}), 64'(0));
            end
            prev_hresp = HRESP;
            if (HSEL && HREADYOUT && HTRANS[1]) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_accept");
                end else begin
                    cur         = exp_q.pop_front();
                    mon_active  = 1'b1;
                    waits       = 0;
                    lreq_cycles = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1);
    end

    // ---------------- main stimulus ----------------
    initial begin : stimulus
        txn_t  t;
        plan_t p;

        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_hreadyout", 64'(HREADYOUT), 64'(1));
        check("rst_hresp", 64'(HRESP), 64'(0));
        check("rst_hrdata", 64'(HRDATA), 64'(0));
        check("rst_local", 64'({LocReq, LocWrite, LocAddr, LocSize, LocByteEn, LocWData}), 64'(0));
        @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // Word write, zero wait states.
        t = mk(32'h010, 1'b1, 3'd2, 0, 1'b0);
        t.wdata = 32'hDEADBEEF;
        send(t, 1'b0);
        // Word read with three LocAck-low cycles.
        t = mk(32'h020, 1'b0, 3'd2, 3, 1'b0);
        t.rdata = 32'h12345678;
        send(t, 1'b0);
        idle_phase();
        // INCR4 word writes, back to back.
        for (int i = 0; i < 4; i++) begin
            t = mk(32'h100 + 32'(4 * i), 1'b1, 3'd2, 0, 1'b0);
            send(t, i != 0);
        end
        // Misaligned half read, then a NONSEQ taken during ERR2.
        t = mk(32'h003, 1'b0, 3'd1, 0, 1'b0);
        send(t, 1'b0);
        t = mk(32'h030, 1'b0, 3'd2, 1, 1'b0);
        send(t, 1'b0);
        // Out-of-range address, oversize transfer, local error on a read.
        t = mk(32'h0000_1000, 1'b0, 3'd2, 0, 1'b0);
        send(t, 1'b0);
        t = mk(32'h008, 1'b1, 3'd3, 0, 1'b0);
        send(t, 1'b1);
        t = mk(32'h040, 1'b0, 3'd2, 2, 1'b1);
        send(t, 1'b0);
        // Byte and half lanes.
        t = mk(32'h002, 1'b1, 3'd0, 0, 1'b0);
        send(t, 1'b0);
        t = mk(32'h007, 1'b1, 3'd0, 1, 1'b0);
        send(t, 1'b1);
        t = mk(32'h00A, 1'b0, 3'd1, 0, 1'b0);
        send(t, 1'b1);
        idle_phase();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) idle_phase();
            t = rand_txn();
            send(t, 1'($urandom_range(0, 1)));
        end
        idle_phase();
        idle_phase();
        drain();

        // Reset while a read is waiting on LocAck.
        mon_en  = 1'b0;
        p.delay = 20;
        p.err   = 1'b0;
        p.rdata = '0;
        plan_q.push_back(p);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h044;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        @(negedge CLK);
        check("mid_accept_ready", 64'(HREADYOUT), 64'(1));
        @(posedge CLK);
        #1;
        HTRANS = 2'b00;
        @(negedge CLK);
        check("mid_locreq", 64'(LocReq), 64'(1));
        check("mid_waiting", 64'(HREADYOUT), 64'(0));
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("rst_mid_locreq", 64'(LocReq), 64'(0));
        check("rst_mid_hreadyout", 64'(HREADYOUT), 64'(1));
        check("rst_mid_hresp", 64'(HRESP), 64'(0));
        check("rst_mid_locaddr", 64'(LocAddr), 64'(0));
        RST_N = 1'b1;
        plan_q.delete();
        exp_q.delete();
        @(posedge CLK);
        #1;
        mon_en = 1'b1;
        // Back in IDLE: a normal read goes straight through.
        t = mk(32'h048, 1'b0, 3'd2, 1, 1'b0);
        send(t, 1'b0);
        idle_phase();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slv_if.md
Name: ahb_slv_if

Overview:
- AHB slave-side front end; the responder counterpart of the team's master interface.
- Accepts pipelined AHB transfers (address phase, then data phase) and converts each beat into a single request/acknowledge transaction on a simple local bus feeding a register file or SRAM.
- Generates HREADYOUT wait states from the local acknowledge.
- Produces the two-cycle ERROR response for illegal accesses and for local errors.

Parameters:
ADDR_WIDTH, 12, local byte-address width; HADDR[31:ADDR_WIDTH] must be zero, otherwise the transfer is an error.

Ports:
CLK        input   1           clock, all logic on rising edge
RST_N      input   1           reset, synchronous, active-low
HSEL       input   1           slave select
HADDR      input   32          transfer address
HTRANS     input   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE     input   1           1 write, 0 read
HSIZE      input   3           0 byte, 1 half, 2 word; larger values illegal
HBURST     input   3           burst type, ignored (each beat handled independently)
HWDATA     input   32          write data, valid in data phase
HREADY     input   1           bus-wide ready (previous data phase complete)
HREADYOUT  output  1           slave ready
HRESP      output  2           00 OKAY, 01 ERROR; 10/11 never driven
HRDATA     output  32          read data
LocReq     output  1           local request, held until LocAck
LocWrite   output  1           local direction
LocAddr    output  ADDR_WIDTH  local byte address
LocSize    output  3           captured HSIZE
LocByteEn  output  4           little-endian byte lanes
LocWData   output  32          local write data
LocAck     input   1           local completion
LocErr     input   1           local error, qualified by LocAck
LocRData   input   32          local read data, valid with LocAck

Behaviour:
- Reset: when RST_N is low at a rising edge, state = IDLE and all captured registers clear. Reset outputs: HREADYOUT 1, HRESP 00, HRDATA 0, LocReq 0, LocWrite 0, LocAddr 0, LocSize 0, LocByteEn 0, LocWData 0.
- Reset mid-transfer: the pending LocReq drops on that edge with no acknowledge required.
- Accept condition: HSEL & HREADY & HTRANS[1]. On acceptance, capture HADDR[ADDR_WIDTH-1:0], HWRITE and HSIZE.
- Not accepted: HTRANS IDLE or BUSY, HSEL low, or HREADY low. Nothing is captured; if the block is otherwise idle, it gives an OKAY response with zero wait states.
- Illegal access, checked at acceptance; any of:
  - HSIZE > 2;
  - HSIZE = 1 with HADDR[0] = 1;
  - HSIZE = 2 with HADDR[1:0] != 0;
  - HADDR[31:ADDR_WIDTH] != 0.
- States:
  - IDLE: HREADYOUT 1, HRESP 00, HRDATA 0, LocReq 0.
    - Accept legal -> DATA; accept illegal -> ERR1; else stay.
  - DATA: LocReq 1; LocWData = HWDATA (combinational pass-through); HREADYOUT = LocAck & ~LocErr; HRDATA = LocRData when read, else 0.
    - LocAck & LocErr -> ERR1.
    - LocAck & ~LocErr with new legal accept -> DATA with new fields (back-to-back, no idle cycle).
    - LocAck & ~LocErr with new illegal accept -> ERR1.
    - LocAck & ~LocErr with no accept -> IDLE.
    - No LocAck -> stay in DATA; new address inputs are ignored because HREADY is low.
  - ERR1: HREADYOUT 0, HRESP 01, LocReq 0 -> ERR2 unconditionally.
  - ERR2: HREADYOUT 1, HRESP 01.
    - Accept legal -> DATA; accept illegal -> ERR1; else IDLE.
- Latency: minimum zero wait states (LocAck high in the first DATA cycle). Each LocAck-low cycle adds exactly one HREADYOUT-low cycle.
- LocByteEn encoding:
  - byte: 0001 << addr[1:0];
  - half: 0011 << {addr[1], 0};
  - word: 1111.
- LocAddr, LocWrite, LocSize and LocByteEn hold the captured values throughout DATA and are 0 in all other states. LocWData is 0 outside DATA.
- LocAck and LocErr are ignored outside DATA.
- The block never issues RETRY or SPLIT. An error on one beat does not stop it accepting later burst beats.

Test Plan:
1. Word write, HADDR 0x010, HWDATA 0xDEADBEEF, LocAck tied 1 -> one LocReq cycle with LocAddr 0x010, LocByteEn 1111, LocWData 0xDEADBEEF; HREADYOUT stays 1; HRESP 00.
2. Word read at 0x020, LocAck after 3 cycles with LocRData 0x12345678 -> HREADYOUT 0 for 3 cycles, then 1 with HRDATA 0x12345678 in the same cycle.
3. INCR4 word writes 0x100/0x104/0x108/0x10C, LocAck tied 1 -> four consecutive LocReq cycles with LocAddr stepping by 4, no gap, no wait states.
4. Half-word read at 0x003 -> LocReq never asserted; HRESP 01 for 2 cycles with HREADYOUT 0 then 1; next NONSEQ in ERR2 is accepted.
5. HADDR 0x0000_1000 with ADDR_WIDTH 12 -> ERROR response as in scenario 4; LocAck with LocErr 1 on a legal read -> same two-cycle ERROR.
6. Byte write at 0x002 -> LocByteEn 0100; separately, RST_N low while DATA waits on LocAck -> LocReq 0 and HREADYOUT 1 after that edge, state IDLE.
